// File: rtl/signed_div_sequencer_pkg.sv
// signed_div_sequencer_pkg: shared state encoding, default width and sign helpers for the signed divider.
package signed_div_sequencer_pkg;
    localparam int DIV_WIDTH = 6;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXUP, DONE} state_t;
    function automatic logic [DIV_WIDTH-1:0] neg(input logic [DIV_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction
    // the most negative value maps onto itself, which reads correctly as an unsigned magnitude
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? neg(x) : x;
    endfunction
endpackage

// File: rtl/signed_div_sequencer_if.sv
// signed_div_sequencer_if: operand/result bundle between the operand source and the divider.
// The overflow flag exists only when SIGNED_DIV_OVF_EN is defined.
interface signed_div_sequencer_if
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             step_sel;
`ifdef SIGNED_DIV_OVF_EN
    logic             overflow;
    modport master(output start, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero, step_sel, overflow);
    modport slave(input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, step_sel, overflow);
`else
    modport master(output start, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero, step_sel);
    modport slave(input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, step_sel);
`endif
endinterface

// File: rtl/signed_div_sequencer_div_step_unit.sv
// div_step_unit: one restoring-division step; shift in a dividend bit, trial-subtract, select.
module div_step_unit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] p,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] p_next,
    output logic             sel
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // the partial remainder stays below |divisor|, so its top bit is always zero
    assign shifted = {p, bit_in};
    assign diff    = shifted - {1'b0, dvs};
    assign sel     = ~diff[WIDTH];
    assign p_next  = sel ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/signed_div_sequencer.sv
// signed_div_sequencer: multi-cycle signed restoring divider sequencer (magnitudes, one step per clock, sign fixup).
// Define SIGNED_DIV_OVF_EN to add the most-negative / -1 overflow flag.
module signed_div_sequencer
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 3
) (
    input logic                   clk,
    input logic                   rst,
    signed_div_sequencer_if.slave bus
);
    state_t           state, nxt;
    logic [WIDTH-1:0] a_reg, b_reg, a_mag, b_mag, p, p_next, quotient, remainder;
    logic [CNT_W-1:0] cnt;
    logic             sq, sr, dbz, sel;
`ifdef SIGNED_DIV_OVF_EN
    logic             ovf;
    assign bus.overflow = ovf;
`endif
    div_step_unit #(.WIDTH(WIDTH)) u_step (
        .p      (p),
        .bit_in (a_mag[WIDTH-1]),
        .dvs    (b_mag),
        .p_next (p_next),
        .sel    (sel)
    );
    always_comb begin
        nxt = state;
        nxt = state == IDLE  ? (bus.start ? LOAD : IDLE) :
              state == LOAD  ? (b_reg == '0 ? DONE : ITER) :
              state == ITER  ? (cnt == '0 ? FIXUP : ITER) :
              state == FIXUP ? DONE : IDLE;
    end
    // a_mag doubles as the quotient shift register: dividend bits leave the top as quotient bits enter the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {a_reg, b_reg, a_mag, b_mag, p, quotient, remainder} <= '0;
            {cnt, sq, sr, dbz} <= '0;
`ifdef SIGNED_DIV_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (bus.start) begin
                    a_reg <= bus.dividend;
                    b_reg <= bus.divisor;
                    dbz   <= 1'b0;
`ifdef SIGNED_DIV_OVF_EN
                    ovf   <= 1'b0;
`endif
                end
                LOAD: begin
                    a_mag <= abs_val(a_reg);
                    b_mag <= abs_val(b_reg);
                    sq    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                    sr    <= a_reg[WIDTH-1];
                    p     <= '0;
                    cnt   <= CNT_W'(WIDTH - 1);
                    if (b_reg == '0) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                        dbz       <= 1'b1;
                    end
                end
                ITER: begin
                    p     <= p_next;
                    a_mag <= {a_mag[WIDTH-2:0], sel};
                    cnt   <= cnt - 1'b1;
                end
                FIXUP: begin
                    quotient  <= sq ? neg(a_mag) : a_mag;
                    remainder <= sr ? neg(p) : p;
`ifdef SIGNED_DIV_OVF_EN
                    ovf       <= a_reg == {1'b1, {(WIDTH-1){1'b0}}} && b_reg == '1;
`endif
                end
                default: ;
            endcase
        end
    end
    assign bus.busy        = state inside {LOAD, ITER, FIXUP};
    assign bus.done        = state == DONE;
    assign bus.step_sel    = state == ITER && sel;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_signed_div_sequencer.sv
// tb_signed_div_sequencer: directed vectors with hand-computed results for the signed divider sequencer.
// Overflow checks are compiled in when SIGNED_DIV_OVF_EN is defined.
module tb_signed_div_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    signed_div_sequencer_if #(.WIDTH(6)) bus ();
    signed_div_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_idle_zero(input string tag);
        check({tag, " q"}, 32'(bus.quotient), 0);
        check({tag, " r"}, 32'(bus.remainder), 0);
        check({tag, " busy"}, 32'(bus.busy), 0);
        check({tag, " done"}, 32'(bus.done), 0);
        check({tag, " dbz"}, 32'(bus.div_by_zero), 0);
        check({tag, " sel"}, 32'(bus.step_sel), 0);
`ifdef SIGNED_DIV_OVF_EN
        check({tag, " ovf"}, 32'(bus.overflow), 0);
`endif
    endtask
    // sel_exp collects step_sel from LOAD to FIXUP: a zero, the quotient magnitude bits MSB first, a zero
    task automatic divide(input string tag, input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] qe, input logic [5:0] re, input logic dz,
                          input int lat, input logic [7:0] sel_exp, input bit repulse);
        int k;
        int busy_n;
        int extra;
        logic [7:0] sel_v;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; busy_n = 0; sel_v = '0;
        while (!bus.done && k < 30) begin
            if (bus.busy) busy_n++;
            sel_v = {sel_v[6:0], bus.step_sel};
            if (repulse && k == 3) begin
                bus.start = 1'b1; bus.dividend = 6'h20; bus.divisor = 6'h01;
            end
            @(negedge clk);
            bus.start = 1'b0;
            k++;
        end
        check({tag, " latency"}, 32'(k + 1), 32'(lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(lat - 1));
        check({tag, " busy at done"}, 32'(bus.busy), 0);
        check({tag, " step_sel"}, 32'(sel_v), 32'(sel_exp));
        check({tag, " q"}, 32'(bus.quotient), 32'(qe));
        check({tag, " r"}, 32'(bus.remainder), 32'(re));
        check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(dz));
`ifdef SIGNED_DIV_OVF_EN
        check({tag, " ovf"}, 32'(bus.overflow), 32'(a == 6'h20 && b == 6'h3F));
`endif
        if (repulse) begin
            bus.start = 1'b1; bus.dividend = 6'h05; bus.divisor = 6'h02;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done width"}, 32'(bus.done), 0);
        check({tag, " idle after done"}, 32'(bus.busy), 0);
        if (repulse) begin
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            check({tag, " extra done"}, 32'(extra), 0);
            check({tag, " q held"}, 32'(bus.quotient), 32'(qe));
            check({tag, " r held"}, 32'(bus.remainder), 32'(re));
        end
    endtask
    initial begin
        int extra;
        rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        divide("13/4",   6'd13, 6'd4,  6'h03, 6'h01, 1'b0, 9, 8'h06, 1'b0);
        divide("-13/4",  6'h33, 6'd4,  6'h3D, 6'h3F, 1'b0, 9, 8'h06, 1'b0);
        divide("13/-4",  6'd13, 6'h3C, 6'h3D, 6'h01, 1'b0, 9, 8'h06, 1'b0);
        divide("-13/-4", 6'h33, 6'h3C, 6'h03, 6'h3F, 1'b0, 9, 8'h06, 1'b0);
        divide("-32/-1", 6'h20, 6'h3F, 6'h20, 6'h00, 1'b0, 9, 8'h40, 1'b0);
        divide("7/0",    6'd7,  6'd0,  6'h3F, 6'h07, 1'b1, 2, 8'h00, 1'b0);
        divide("5/5",    6'd5,  6'd5,  6'h01, 6'h00, 1'b0, 9, 8'h02, 1'b0);
        divide("-13/4b", 6'h33, 6'd4,  6'h3D, 6'h3F, 1'b0, 9, 8'h06, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 6'd13; bus.divisor = 6'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("abort no done", 32'(extra), 0);
        divide("9/2",     6'd9,  6'd2,  6'h04, 6'h01, 1'b0, 9, 8'h08, 1'b0);
        divide("repulse", 6'd13, 6'd4,  6'h03, 6'h01, 1'b0, 9, 8'h06, 1'b1);
        divide("31/-32",  6'h1F, 6'h20, 6'h00, 6'h1F, 1'b0, 9, 8'h00, 1'b0);
        divide("-32/-32", 6'h20, 6'h20, 6'h01, 6'h00, 1'b0, 9, 8'h02, 1'b0);
        divide("-32/1",   6'h20, 6'h01, 6'h20, 6'h00, 1'b0, 9, 8'h40, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
